// File: rtl/neuron_pkg.sv
// Shared types and defaults for the single-neuron MAC stage.
package neuron_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCALE = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int unsigned N_IN_DEF  = 4;
  localparam int unsigned ACC_W_DEF = 20;
  localparam int unsigned SHIFT_DEF = 4;
  localparam int unsigned OUT_MAX   = 255;

endpackage

// File: rtl/neuron_relu_sat.sv
// Scale the accumulated sum, apply ReLU and saturate to an unsigned byte.
module neuron_relu_sat
  import neuron_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned SHIFT = SHIFT_DEF
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic        [7:0]       res_c
);

  logic signed [ACC_W-1:0] s;

  // Negative sums clamp to 0; any set bit above bit 7 of a positive sum saturates.
  always_comb begin
    s = acc >>> SHIFT;
    if (s[ACC_W-1]) begin
      res_c = '0;
    end else if (|s[ACC_W-2:8]) begin
      res_c = 8'(OUT_MAX);
    end else begin
      res_c = s[7:0];
    end
  end

endmodule

// File: rtl/neuron_mac_seq.sv
// Sequential single-neuron MAC: streams N_IN activations against stored weights,
// then scales, rectifies and presents one unsigned byte downstream.
module neuron_mac_seq
  import neuron_pkg::*;
#(
  parameter int unsigned N_IN  = N_IN_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned SHIFT = SHIFT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       w_load,
  input  logic [7:0] w_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
);

  localparam int unsigned IDX_W  = $clog2(N_IN);
  localparam int unsigned PROD_W = 16;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic        [IDX_W-1:0]  idx_q, idx_d;
  logic        [IDX_W-1:0]  wptr_q, wptr_d;
  logic signed [7:0]        w_q [N_IN];
  logic signed [7:0]        w_d [N_IN];
  logic                     out_valid_d;
  logic        [7:0]        out_data_d;

  logic        [IDX_W-1:0]  idx_sel;
  logic signed [7:0]        w_sel;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic        [7:0]        relu_c;

  // Handshake-facing status decoded straight from the state register.
  assign in_ready = (state_q == IDLE) || (state_q == ACCUM);
  assign busy     = (state_q != IDLE);

  // Signed 8x8 product; the first beat of an evaluation always pairs with w[0].
  always_comb begin
    idx_sel  = (state_q == IDLE) ? '0 : idx_q;
    w_sel    = w_q[idx_sel];
    prod     = PROD_W'($signed(in_data)) * PROD_W'(w_sel);
    prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  end

  neuron_relu_sat #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_relu_sat (
    .acc   (acc_q),
    .res_c (relu_c)
  );

  // Next-state and datapath updates; everything holds while ena is low.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    wptr_d      = wptr_q;
    w_d         = w_q;
    out_valid_d = out_valid;
    out_data_d  = out_data;

    if (ena) begin
      unique case (state_q)
        IDLE: begin
          if (w_load) begin
            w_d[wptr_q] = w_data;
            wptr_d      = (wptr_q == IDX_W'(N_IN-1)) ? '0 : wptr_q + IDX_W'(1);
          end
          if (in_valid) begin
            acc_d   = prod_ext;
            idx_d   = IDX_W'(1);
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_d = acc_q + prod_ext;
            if (idx_q == IDX_W'(N_IN-1)) begin
              idx_d   = '0;
              state_d = SCALE;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        SCALE: begin
          out_data_d  = relu_c;
          out_valid_d = 1'b1;
          state_d     = OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, weight and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      idx_q     <= '0;
      wptr_q    <= '0;
      for (int i = 0; i < int'(N_IN); i++) begin
        w_q[i] <= '0;
      end
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      wptr_q    <= wptr_d;
      w_q       <= w_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Scoreboard bench: two instances (SHIFT=4 and SHIFT=0) share one stimulus stream.
module tb_neuron_mac_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       w_load = 1'b0;
  logic [7:0] w_data = 8'd0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       out_ready = 1'b1;

  logic       in_ready, out_valid, busy;
  logic [7:0] out_data;
  logic       in_ready0, out_valid0, busy0;
  logic [7:0] out_data0;

  int w_m [4];
  int wptr_m = 0;
  int beat_m = 0;
  int acc_m  = 0;
  int exp4_q[$];
  int exp0_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  neuron_mac_seq dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .w_load(w_load), .w_data(w_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  neuron_mac_seq #(.SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .w_load(w_load), .w_data(w_data),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .busy(busy0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int sat(input int s);
    if (s < 0) return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  task automatic load_w(input int val, input bit honoured);
    w_load = 1'b1;
    w_data = 8'(val);
    @(negedge clk);
    w_load = 1'b0;
    if (honoured) begin
      w_m[wptr_m] = val;
      wptr_m = (wptr_m + 1) % 4;
    end
  endtask

  task automatic send(input int a);
    int t;
    in_valid = 1'b1;
    in_data  = 8'(a);
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    acc_m = (beat_m == 0) ? a * w_m[0] : acc_m + a * w_m[beat_m];
    beat_m++;
    if (beat_m == 4) begin
      exp4_q.push_back(sat(acc_m >>> 4));
      exp0_q.push_back(sat(acc_m));
      beat_m = 0;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout", int'(busy), 0);
  endtask

  // Scoreboard: compare results at the point the handshake is about to complete.
  always begin
    @(negedge clk);
    #1;
    if (rst_n && ena && out_valid && out_ready) begin
      if (exp4_q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        check("out_data_s4", int'(out_data), exp4_q.pop_front());
        check("out_data_s0", int'(out_data0), exp0_q.pop_front());
        check("out_valid_s0", int'(out_valid0), 1);
      end
    end
  end

  initial begin
    foreach (w_m[i]) w_m[i] = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic dot product with timing around SCALE/OUT
    load_w(1, 1); load_w(2, 1); load_w(3, 1); load_w(4, 1);
    out_ready = 1'b1;
    send(10); send(10); send(10);
    check("accum_ready", int'(in_ready), 1);
    send(10);
    check("scale_busy", int'(busy), 1);
    check("scale_ready", int'(in_ready), 0);
    check("scale_valid", int'(out_valid), 0);
    @(negedge clk);
    check("out_valid_rise", int'(out_valid), 1);
    check("out_ready_low", int'(in_ready), 0);
    @(negedge clk);
    check("back_idle", int'(busy), 0);
    check("back_ready", int'(in_ready), 1);
    check("valid_cleared", int'(out_valid), 0);

    // ReLU clamp
    load_w(-1, 1); load_w(-2, 1); load_w(-3, 1); load_w(-4, 1);
    repeat (4) send(10);
    wait_idle();

    // Saturation
    repeat (4) load_w(127, 1);
    repeat (4) send(127);
    wait_idle();

    // Backpressure: result stable, new beats refused
    out_ready = 1'b0;
    send(1); send(1); send(1); send(-1);
    begin
      int t;
      t = 0;
      while (!out_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
      check("bp_valid_seen", int'(out_valid), 1);
    end
    in_valid = 1'b1;
    in_data  = 8'd55;
    repeat (5) begin
      @(negedge clk);
      check("bp_valid_hold", int'(out_valid), 1);
      check("bp_no_ready", int'(in_ready), 0);
      if (exp4_q.size() > 0) begin
        check("bp_data_s4", int'(out_data), exp4_q[0]);
        check("bp_data_s0", int'(out_data0), exp0_q[0]);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_idle", int'(busy), 0);

    // Clock enable: load ignored in IDLE, beats held in ACCUM, handshake held in OUT
    ena = 1'b0;
    load_w(99, 0);
    ena = 1'b1;
    send(1); send(1);
    ena = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'd100;
    repeat (3) begin
      @(negedge clk);
      check("ena_accum_hold", int'(busy), 1);
    end
    in_valid = 1'b0;
    ena = 1'b1;
    out_ready = 1'b0;
    send(1); send(1);
    @(negedge clk);
    ena = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("ena_out_hold", int'(out_valid), 1);
    end
    ena = 1'b1;
    wait_idle();

    // Weight pointer wrap and load gating during ACCUM
    load_w(1, 1); load_w(2, 1); load_w(3, 1); load_w(4, 1); load_w(9, 1);
    send(1);
    load_w(5, 0);
    send(1); send(1); send(1);
    wait_idle();

    // Same-cycle load and first beat: product uses the old w[0]
    load_w(20, 1); load_w(30, 1); load_w(40, 1);
    w_load = 1'b1;
    w_data = 8'd100;
    send(2);
    w_load = 1'b0;
    w_m[wptr_m] = 100;
    wptr_m = (wptr_m + 1) % 4;
    send(1); send(1); send(1);
    wait_idle();
    repeat (4) send(1);
    wait_idle();

    // Asynchronous reset mid-evaluation
    send(5); send(5);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_ready", int'(in_ready), 1);
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_data_s4", int'(out_data), 0);
    check("mid_rst_data_s0", int'(out_data0), 0);
    check("mid_rst_busy_s0", int'(busy0), 0);
    check("mid_rst_ready_s0", int'(in_ready0), 1);
    foreach (w_m[i]) w_m[i] = 0;
    wptr_m = 0;
    beat_m = 0;
    acc_m  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    repeat (4) send(50);
    wait_idle();
    load_w(1, 1); load_w(0, 1); load_w(0, 1); load_w(0, 1);
    send(80); send(1); send(1); send(1);
    wait_idle();

    check("scoreboard_drained", exp4_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/neuron_mac_seq.md
# neuron_mac_seq

Sequential single-neuron multiply-accumulate stage for the neural-net tile. It holds N_IN signed 8-bit weights and accepts N_IN signed 8-bit activations over a valid/ready stream, one per cycle. It computes the dot product, scales it, and applies ReLU with unsigned saturation. It presents one unsigned 8-bit result to the downstream output/summing stage that drives the `uo_out` pins.

## Interface
Parameters:
- `N_IN`, 4: activations (and weights) per neuron evaluation; ≥2.
- `ACC_W`, 20: accumulator width; must be ≥ 16 + clog2(N_IN).
- `SHIFT`, 4: arithmetic right shift applied to the final sum before activation.

Ports:
- `clk`, input, 1: single clock; all state on rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `ena`, input, 1: clock enable; when 0, all state holds.
- `w_load`, input, 1: write `w_data` into weight slot `wptr`.
- `w_data`, input, 8: signed weight.
- `in_valid`, input, 1: activation beat valid.
- `in_ready`, output, 1: stage accepts activation.
- `in_data`, input, 8: signed activation.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: downstream accepts result.
- `out_data`, output, 8: unsigned ReLU/saturated result.
- `busy`, output, 1: high in any state other than IDLE.

## Operation
- **FSM states:** IDLE, ACCUM, SCALE, OUT.
- **IDLE**
  - `in_ready`=1.
  - An accepted beat (`in_valid`&`in_ready`) loads `acc` = `in_data`*`w[0]`, sets `idx`=1, and moves to ACCUM. This overwrites, and never adds to, the previous `acc`.
- **ACCUM**
  - `in_ready`=1.
  - Each accepted beat does `acc` += `in_data`*`w[idx]` and `idx`++.
  - The beat with `idx`==N_IN-1 moves to SCALE.
  - Cycles with no accepted beat hold all state. There is no timeout.
- **SCALE**
  - `in_ready`=0.
  - Computes `s` = `acc` >>> SHIFT (arithmetic). The result is 0 if `s`<0, 255 if `s`>255, otherwise `s[7:0]`.
  - Registers the result into `out_data`, asserts `out_valid`, and moves to OUT.
- **OUT**
  - `in_ready`=0.
  - `out_valid` and `out_data` stay stable until `out_valid`&`out_ready`. On that handshake, `out_valid` is cleared and the FSM moves to IDLE.
- **Arithmetic:** products are signed 8×8 → 16 bits, sign-extended to ACC_W. No overflow is possible given the ACC_W rule.
- **Weight load**
  - Honoured only in IDLE: `w[wptr]` ← `w_data`, then `wptr`++, wrapping N_IN-1 → 0.
  - `w_load` in any other state is ignored and `wptr` is unchanged.
  - Weights persist across evaluations.
  - In IDLE, `w_load` and an accepted activation beat in the same cycle are both honoured. The product for that beat uses the old `w[0]`.
- **`ena`=0:** the FSM, `acc`, `idx`, `wptr`, weights and outputs all hold. Handshakes are not honoured in that cycle, and outputs stay driven at their held values.
- **Reset (async, any state):**
  - FSM → IDLE.
  - `acc`, `idx`, `wptr`, all weights, and `out_data` → 0.
  - `out_valid` → 0.
  - `in_ready` → 1 (combinational from IDLE), `busy` → 0.
  - A partial evaluation is discarded.

## Timing
- `in_ready` and `busy` are combinational decodes of the state register. `out_valid` and `out_data` are registered.
- The last activation is accepted at edge k (→ SCALE). At edge k+1, `out_data` is registered and `out_valid` rises.
- Minimum period between results is N_IN+2 cycles with `out_ready` held high:
  - N_IN accept cycles;
  - 1 SCALE cycle;
  - 1 OUT cycle, in which the handshake occurs and returns the FSM to IDLE.
- The next evaluation's first beat can be accepted in the cycle after the output handshake, not the same cycle.
- Backpressure: `out_ready`=0 holds OUT indefinitely, and `in_ready` stays 0 throughout.

## Structure
- **Package `neuron_pkg`:**
  - `state_t` enum (IDLE, ACCUM, SCALE, OUT);
  - default constants `N_IN_DEF`=4, `ACC_W_DEF`=20, `SHIFT_DEF`=4;
  - saturation limit constant `OUT_MAX`=255.
- **Sub-module `neuron_relu_sat`:** combinational, parameterised by ACC_W and SHIFT. It takes `acc` and returns the 8-bit result, and is instantiated once feeding the SCALE-stage register.
- The top level holds the FSM, weight register array, `wptr`, `idx`, and the MAC datapath.

## Test plan
- **Basic dot product:**
  - load weights 1,2,3,4;
  - stream activations 10,10,10,10 with `out_ready`=1;
  - expect `out_data`=6 (100>>>4), with `out_valid` exactly 1 cycle after the SCALE cycle;
  - `in_ready`=0 for 2 cycles.
- **ReLU clamp:** weights -1,-2,-3,-4 with activations 10×4 → `acc`=-100 → `out_data`=0.
- **Saturation:** weights 127×4 with activations 127×4 → `acc`=64516 → 4032 → `out_data`=255.
- **Backpressure:**
  - hold `out_ready`=0 for 5 cycles after `out_valid`;
  - `out_data` must be stable, and `in_valid`=1 beats must not be accepted (`in_ready`=0);
  - after the release, the FSM returns to IDLE one edge later.
- **Weight wrap and gating:**
  - 5 loads 1,2,3,4,9 in IDLE → `w`={9,2,3,4};
  - `w_load` asserted during ACCUM is ignored;
  - activations 1,1,1,1 with SHIFT=0 build → `out_data`=18.
- **Reset mid-operation:**
  - assert `rst_n`=0 asynchronously after 2 accepted beats;
  - all outputs go to their reset values immediately and weights are cleared;
  - a following evaluation with all-zero weights yields 0.
